// File: rtl/traffic_light_ctrl.sv
// traffic_light_ctrl: two-way intersection sequencer on the 50 MHz board clock.
// An internal prescaler produces a one-cycle 1 s tick enable. A six-phase FSM
// drives the NS/EW lamps, exports the seconds left in the current phase, and
// shortens an active green when a latched pedestrian request is pending.
// Optional night flashing mode: define TRAFFIC_NIGHT_FLASH_EN.
//
// Handshake note: ped_req is a plain level with no ready. Any clock that sees
// it high latches a pending request. ped_ack is a single-cycle pulse, issued
// only in the cycle where that request shortens a green.
module traffic_light_ctrl #(
  parameter int TICK_DIV    = 50000000,
  parameter int T_NS_GREEN  = 25,
  parameter int T_EW_GREEN  = 20,
  parameter int T_YELLOW    = 3,
  parameter int T_ALL_RED   = 2,
  parameter int T_PED_SHORT = 5
) (
  input  logic       clk50M,
  input  logic       Reset,
  input  logic       ped_req,
`ifdef TRAFFIC_NIGHT_FLASH_EN
  input  logic       night_mode,
`endif
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic [7:0] remain,
  output logic       tick,
  output logic       ped_ack
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

  localparam logic [7:0] L_NS_GREEN  = 8'(T_NS_GREEN);
  localparam logic [7:0] L_EW_GREEN  = 8'(T_EW_GREEN);
  localparam logic [7:0] L_YELLOW    = 8'(T_YELLOW);
  localparam logic [7:0] L_ALL_RED   = 8'(T_ALL_RED);
  localparam logic [7:0] L_PED_SHORT = 8'(T_PED_SHORT);

  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;

  typedef enum logic [2:0] {
    ALL_RED_1 = 3'd0,
    NS_GREEN  = 3'd1,
    NS_YELLOW = 3'd2,
    ALL_RED_2 = 3'd3,
    EW_GREEN  = 3'd4,
    EW_YELLOW = 3'd5
`ifdef TRAFFIC_NIGHT_FLASH_EN
    ,
    FLASH     = 3'd6
`endif
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] count;
  logic          tick_cond;
  logic          ped_pending;
  logic          pend_next;
  logic [7:0]    remain_next;
  logic          ack_next;
  logic          flash_on;
  logic          flash_on_next;
  logic [2:0]    ns_next;
  logic [2:0]    ew_next;

  // The tick fires on the prescaler terminal count. The FSM advances on the
  // same edge that raises the registered tick output.
  assign tick_cond = (count == CNT_LAST);

  // Duration that is loaded when a phase is entered.
  function automatic logic [7:0] load_of(state_t s);
    case (s)
      NS_GREEN:  load_of = L_NS_GREEN;
      NS_YELLOW: load_of = L_YELLOW;
      EW_GREEN:  load_of = L_EW_GREEN;
      EW_YELLOW: load_of = L_YELLOW;
      default:   load_of = L_ALL_RED;
    endcase
  endfunction

  // Phase successor in the fixed six-phase ring.
  function automatic state_t succ_of(state_t s);
    case (s)
      ALL_RED_1: succ_of = NS_GREEN;
      NS_GREEN:  succ_of = NS_YELLOW;
      NS_YELLOW: succ_of = ALL_RED_2;
      ALL_RED_2: succ_of = EW_GREEN;
      EW_GREEN:  succ_of = EW_YELLOW;
      default:   succ_of = ALL_RED_1;
    endcase
  endfunction

  // Next-state logic: phase timing, pedestrian shortening and lamp decode.
  always_comb begin
    state_next    = state;
    remain_next   = remain;
    ack_next      = 1'b0;
    pend_next     = ped_pending | ped_req;
    flash_on_next = flash_on;
    ns_next       = LAMP_RED;
    ew_next       = LAMP_RED;

    if (tick_cond) begin
      if (remain == 8'd1) begin
        // When the phase ends on the same tick as a pending request,
        // the phase transition wins.
        state_next  = succ_of(state);
        remain_next = load_of(succ_of(state));
      end else if ((state == NS_GREEN || state == EW_GREEN) && ped_pending &&
                   (remain > L_PED_SHORT)) begin
        remain_next = L_PED_SHORT;
        ack_next    = 1'b1;
      end else begin
        remain_next = remain - 8'd1;
      end
    end

`ifdef TRAFFIC_NIGHT_FLASH_EN
    // In night mode, a tick overrides the normal sequence from any phase.
    if (tick_cond) begin
      if (night_mode) begin
        state_next    = FLASH;
        remain_next   = 8'd0;
        ack_next      = 1'b0;
        flash_on_next = (state == FLASH) ? ~flash_on : 1'b1;
      end else if (state == FLASH) begin
        state_next  = ALL_RED_1;
        remain_next = L_ALL_RED;
        ack_next    = 1'b0;
      end
    end
`endif

    // Entering an all-red phase drops the request unless the button is held.
    if (tick_cond && (state_next != state) &&
        (state_next == ALL_RED_1 || state_next == ALL_RED_2) && !ped_req) begin
      pend_next = 1'b0;
    end

    case (state_next)
      NS_GREEN:  ns_next = LAMP_GREEN;
      NS_YELLOW: ns_next = LAMP_YELLOW;
      EW_GREEN:  ew_next = LAMP_GREEN;
      EW_YELLOW: ew_next = LAMP_YELLOW;
`ifdef TRAFFIC_NIGHT_FLASH_EN
      FLASH: begin
        ns_next = flash_on_next ? LAMP_YELLOW : 3'b000;
        ew_next = flash_on_next ? LAMP_YELLOW : 3'b000;
      end
`endif
      default: begin
        ns_next = LAMP_RED;
        ew_next = LAMP_RED;
      end
    endcase

`ifdef TRAFFIC_NIGHT_FLASH_EN
    // Requests are ignored while flashing.
    if (state_next == FLASH) begin
      pend_next = 1'b0;
    end
`endif
  end

  // State, prescaler and registered outputs. Reset restores every value,
  // including the prescaler phase.
  always_ff @(posedge clk50M) begin
    if (Reset) begin
      count       <= '0;
      tick        <= 1'b0;
      state       <= ALL_RED_1;
      remain      <= L_ALL_RED;
      ns_light    <= LAMP_RED;
      ew_light    <= LAMP_RED;
      ped_ack     <= 1'b0;
      ped_pending <= 1'b0;
      flash_on    <= 1'b0;
    end else begin
      count       <= tick_cond ? '0 : count + 1'b1;
      tick        <= tick_cond;
      state       <= state_next;
      remain      <= remain_next;
      ns_light    <= ns_next;
      ew_light    <= ew_next;
      ped_ack     <= ack_next;
      ped_pending <= pend_next;
      flash_on    <= flash_on_next;
    end
  end

endmodule
